// File: rtl/shift_sched_if.sv
// Request/grant handshake and serializer outputs shared between shift_sched and its requesters.
interface shift_sched_if #(
    parameter int WIDTH = 16
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] data;
    logic [3:0]         grant;
    logic [3:0]         ack;
    logic               shld;
    logic               serclk;
    logic               sdata;
    logic [4:0]         count;
    logic               busy;
    logic               done;

    modport master (
        output req, data,
        input  grant, ack, shld, serclk, sdata, count, busy, done
    );

    modport slave (
        input  req, data,
        output grant, ack, shld, serclk, sdata, count, busy, done
    );
endinterface

// File: rtl/shift_sched.sv
// Four-requester round-robin scheduler feeding one MSB-first serializer.
// state | meaning
// IDLE  | arbitrate among req, grant registered on exit
// LOAD  | one cycle, shld high, word captured from the granted slice
// SHIFT | each bit is CLKDIV cycles serclk low then CLKDIV cycles serclk high
// DONE  | one cycle, done and ack pulse, last-granted pointer updated
module shift_sched #(
    parameter int WIDTH  = 16,
    parameter int CLKDIV = 2
) (
    input  logic         clk,
    input  logic         reset,
    shift_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam int              DIVW     = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLKDIV - 1);

    state_t           state, state_nxt;
    logic [3:0]       grant_q;
    logic [1:0]       gidx;
    logic [1:0]       last_ptr;
    logic [1:0]       win_idx;
    logic [1:0]       cand;
    logic             win_ok;
    logic [WIDTH-1:0] shreg;
    logic [4:0]       cnt;
    logic [DIVW-1:0]  div_cnt;
    logic             serclk_q;
    logic             bit_end;
    logic             shld_c, busy_c, done_c;
    logic [3:0]       ack_c;

    // Search upward from the requester after the one served last.
    always_comb begin
        win_ok  = 1'b0;
        win_idx = last_ptr;
        cand    = last_ptr;
        for (int k = 1; k <= 4; k++) begin
            cand = last_ptr + 2'(k);
            if (!win_ok && bus.req[cand]) begin
                win_ok  = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign bit_end = (state == SHIFT) && (div_cnt == '0) && serclk_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shld_c    = 1'b0;
        busy_c    = 1'b1;
        done_c    = 1'b0;
        ack_c     = 4'b0000;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (win_ok) state_nxt = LOAD;
            end
            LOAD: begin
                shld_c    = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                if (bit_end && cnt == 5'd1) state_nxt = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                ack_c     = grant_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_q  <= 4'b0000;
            gidx     <= 2'd0;
            last_ptr <= 2'd3;
            shreg    <= '0;
            cnt      <= 5'd0;
            div_cnt  <= '0;
            serclk_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_ok) begin
                        grant_q <= 4'b0001 << win_idx;
                        gidx    <= win_idx;
                        cnt     <= 5'(WIDTH);
                    end
                end
                LOAD: begin
                    shreg    <= bus.data[gidx*WIDTH +: WIDTH];
                    cnt      <= 5'(WIDTH);
                    serclk_q <= 1'b0;
                    div_cnt  <= DIV_LAST;
                end
                SHIFT: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        div_cnt <= DIV_LAST;
                        if (serclk_q) begin
                            shreg    <= shreg << 1;
                            cnt      <= cnt - 5'd1;
                            serclk_q <= 1'b0;
                        end else begin
                            serclk_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    grant_q  <= 4'b0000;
                    last_ptr <= gidx;
                end
                default: ;
            endcase
        end
    end

    assign bus.grant  = grant_q;
    assign bus.ack    = ack_c;
    assign bus.shld   = shld_c;
    assign bus.serclk = serclk_q;
    assign bus.sdata  = (state == SHIFT) && shreg[WIDTH-1];
    assign bus.count  = cnt;
    assign bus.busy   = busy_c;
    assign bus.done   = done_c;
endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched: a 16-bit/CLKDIV=2 instance and a 1-bit/CLKDIV=1 instance.
module tb_shift_sched;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    shift_sched_if #(.WIDTH(16)) bus_a ();
    shift_sched_if #(.WIDTH(1))  bus_b ();

    shift_sched #(.WIDTH(16), .CLKDIV(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    shift_sched #(.WIDTH(1),  .CLKDIV(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    typedef struct {
        int          cyc;
        logic [3:0]  req;
        logic [15:0] dlo;
        logic        shld;
        logic        serclk;
        logic [4:0]  count;
        logic        busy;
        logic        done;
        logic [3:0]  ack;
        logic [3:0]  grant;
    } vec_t;

    typedef struct {
        logic [3:0] req_set;
        bit         sticky;
        logic [3:0] grant;
    } rr_t;

    localparam int NV  = 11;
    localparam int NRR = 8;

    vec_t        tv[NV];
    rr_t         rr[NRR];
    logic [15:0] words[4];
    int          n_total = 0;
    int          n_pass  = 0;
    logic        inv_bad = 1'b0;
    int          ack_cnt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Advance one clock and sample 1 time unit after the edge; watch invariants on every sample.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!$onehot0(bus_a.grant) || !$onehot0(bus_a.ack) || ((bus_a.ack & ~bus_a.grant) != 4'b0)) inv_bad = 1'b1;
        if (!$onehot0(bus_b.grant) || !$onehot0(bus_b.ack) || ((bus_b.ack & ~bus_b.grant) != 4'b0)) inv_bad = 1'b1;
        if (!bus_a.busy && (bus_a.serclk || bus_a.sdata)) inv_bad = 1'b1;
        if (!bus_b.busy && (bus_b.serclk || bus_b.sdata)) inv_bad = 1'b1;
        for (int i = 0; i < 4; i++) if (bus_a.ack[i]) ack_cnt[i]++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Entered in cycle 0 (IDLE, req already driven); returns in the IDLE cycle after DONE.
    task automatic run_a(input string name, input logic [3:0] exp_g, input bit sticky,
                         input int drop_at, input logic [15:0] exp_word);
        int          cyc;
        logic [15:0] word;
        logic        prev_s;
        chk({name, " idle"}, 32'(bus_a.busy), 32'd0);
        tick();
        cyc = 1;
        chk({name, " shld"}, 32'(bus_a.shld), 32'd1);
        chk({name, " grant"}, 32'(bus_a.grant), 32'(exp_g));
        word   = 16'h0;
        prev_s = 1'b0;
        while (!bus_a.done && cyc < 300) begin
            tick();
            cyc++;
            if (bus_a.serclk && !prev_s) word = {word[14:0], bus_a.sdata};
            prev_s = bus_a.serclk;
            if (cyc == drop_at) bus_a.req = bus_a.req & ~exp_g;
        end
        chk({name, " done cycle"}, 32'(cyc), 32'd66);
        chk({name, " ack"}, 32'(bus_a.ack), 32'(exp_g));
        chk({name, " word"}, 32'(word), 32'(exp_word));
        if (!sticky) bus_a.req = bus_a.req & ~exp_g;
        tick();
    endtask

    initial begin
        int          r;
        int          gi;
        int          wait_n;
        logic [15:0] word;
        logic        prev_s, prev_d, unstable;

        words[0] = 16'hA5C3;
        words[1] = 16'h1234;
        words[2] = 16'h0F0F;
        words[3] = 16'h8001;

        //            cyc req      dlo       shld  sclk  count  busy  done  ack      grant
        tv[0]  = '{0,  4'b0001, 16'hA5C3, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 4'b0000, 4'b0000};
        tv[1]  = '{1,  4'b0001, 16'hA5C3, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 4'b0000, 4'b0001};
        tv[2]  = '{2,  4'b0001, 16'hA5C3, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 4'b0000, 4'b0001};
        tv[3]  = '{4,  4'b0001, 16'hA5C3, 1'b0, 1'b1, 5'd16, 1'b1, 1'b0, 4'b0000, 4'b0001};
        tv[4]  = '{6,  4'b0001, 16'hA5C3, 1'b0, 1'b0, 5'd15, 1'b1, 1'b0, 4'b0000, 4'b0001};
        tv[5]  = '{10, 4'b0001, 16'hFFFF, 1'b0, 1'b0, 5'd14, 1'b1, 1'b0, 4'b0000, 4'b0001};
        tv[6]  = '{33, 4'b0001, 16'hFFFF, 1'b0, 1'b1, 5'd9,  1'b1, 1'b0, 4'b0000, 4'b0001};
        tv[7]  = '{65, 4'b0001, 16'hFFFF, 1'b0, 1'b1, 5'd1,  1'b1, 1'b0, 4'b0000, 4'b0001};
        tv[8]  = '{66, 4'b0000, 16'hA5C3, 1'b0, 1'b0, 5'd0,  1'b1, 1'b1, 4'b0001, 4'b0001};
        tv[9]  = '{67, 4'b0000, 16'hA5C3, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 4'b0000, 4'b0000};
        tv[10] = '{68, 4'b0000, 16'hA5C3, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 4'b0000, 4'b0000};

        rr[0] = '{4'b1111, 1'b0, 4'b0001};
        rr[1] = '{4'b0000, 1'b0, 4'b0010};
        rr[2] = '{4'b0000, 1'b0, 4'b0100};
        rr[3] = '{4'b0000, 1'b0, 4'b1000};
        rr[4] = '{4'b1010, 1'b1, 4'b0010};
        rr[5] = '{4'b0000, 1'b1, 4'b1000};
        rr[6] = '{4'b0000, 1'b1, 4'b0010};
        rr[7] = '{4'b0000, 1'b1, 4'b1000};

        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        bus_a.req  = 4'b0000;
        bus_a.data = {words[3], words[2], words[1], words[0]};
        bus_b.req  = 4'b0000;
        bus_b.data = 4'b0001;
        reset      = 1'b1;
        #1;
        chk("reset outputs", 32'({bus_a.grant, bus_a.ack, bus_a.shld, bus_a.serclk, bus_a.sdata,
                                  bus_a.count, bus_a.busy, bus_a.done}), 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // Single transfer, table-driven per cycle; data slice is changed mid-SHIFT.
        r        = 0;
        word     = 16'h0;
        prev_s   = 1'b0;
        prev_d   = 1'b0;
        unstable = 1'b0;
        for (int cyc = 0; cyc <= 68; cyc++) begin
            if (r < NV && tv[r].cyc == cyc) begin
                chk($sformatf("single c%0d shld", cyc), 32'(bus_a.shld), 32'(tv[r].shld));
                chk($sformatf("single c%0d serclk", cyc), 32'(bus_a.serclk), 32'(tv[r].serclk));
                chk($sformatf("single c%0d count", cyc), 32'(bus_a.count), 32'(tv[r].count));
                chk($sformatf("single c%0d busy", cyc), 32'(bus_a.busy), 32'(tv[r].busy));
                chk($sformatf("single c%0d done", cyc), 32'(bus_a.done), 32'(tv[r].done));
                chk($sformatf("single c%0d ack", cyc), 32'(bus_a.ack), 32'(tv[r].ack));
                chk($sformatf("single c%0d grant", cyc), 32'(bus_a.grant), 32'(tv[r].grant));
                bus_a.req        = tv[r].req;
                bus_a.data[15:0] = tv[r].dlo;
                r++;
            end
            if (bus_a.serclk && !prev_s) word = {word[14:0], bus_a.sdata};
            if (bus_a.serclk && prev_s && bus_a.sdata != prev_d) unstable = 1'b1;
            prev_s = bus_a.serclk;
            prev_d = bus_a.sdata;
            if (cyc < 68) tick();
        end
        chk("single rows applied", 32'(r), 32'(NV));
        chk("single word", 32'(word), 32'h0000A5C3);
        chk("single sdata stable high", 32'(unstable), 32'd0);

        // Round-robin with everyone requesting, then two requesters held continuously.
        do_reset();
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        for (int k = 0; k < NRR; k++) begin
            bus_a.req = bus_a.req | rr[k].req_set;
            gi = 0;
            for (int i = 0; i < 4; i++) if (rr[k].grant[i]) gi = i;
            run_a($sformatf("rr%0d", k), rr[k].grant, rr[k].sticky, -1, words[gi]);
            if (k == 3) begin
                for (int i = 0; i < 4; i++)
                    chk($sformatf("rr ack count %0d", i), 32'(ack_cnt[i]), 32'd1);
            end
        end
        bus_a.req = 4'b0000;
        do_reset();

        // Granted requester drops req at cycle 10; word still completes and acks.
        bus_a.req = 4'b0100;
        run_a("drop", 4'b0100, 1'b0, 10, words[2]);

        // Reset mid-SHIFT abandons the word without ack.
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        bus_a.req = 4'b0001;
        wait_n    = 0;
        while (bus_a.count != 5'd7 && wait_n < 200) begin
            tick();
            wait_n++;
        end
        chk("midreset reached count 7", 32'(bus_a.count), 32'd7);
        chk("midreset busy before", 32'(bus_a.busy), 32'd1);
        reset     = 1'b1;
        bus_a.req = 4'b0000;
        #1;
        chk("midreset outputs immediate", 32'({bus_a.grant, bus_a.ack, bus_a.shld, bus_a.serclk,
                                              bus_a.sdata, bus_a.count, bus_a.busy, bus_a.done}), 32'd0);
        tick();
        chk("midreset outputs held", 32'({bus_a.grant, bus_a.ack, bus_a.shld, bus_a.serclk,
                                          bus_a.sdata, bus_a.count, bus_a.busy, bus_a.done}), 32'd0);
        reset = 1'b0;
        chk("midreset no ack", 32'(ack_cnt[0]), 32'd0);
        bus_a.req = 4'b1000;
        run_a("postreset", 4'b1000, 1'b0, -1, words[3]);

        // WIDTH=1, CLKDIV=1 boundary instance.
        bus_b.req = 4'b0001;
        chk("w1 c0 busy", 32'(bus_b.busy), 32'd0);
        tick();
        chk("w1 c1 shld", 32'(bus_b.shld), 32'd1);
        chk("w1 c1 grant", 32'(bus_b.grant), 32'b0001);
        tick();
        chk("w1 c2 serclk", 32'(bus_b.serclk), 32'd0);
        chk("w1 c2 count", 32'(bus_b.count), 32'd1);
        tick();
        chk("w1 c3 serclk", 32'(bus_b.serclk), 32'd1);
        chk("w1 c3 sdata", 32'(bus_b.sdata), 32'd1);
        tick();
        chk("w1 c4 done", 32'(bus_b.done), 32'd1);
        chk("w1 c4 ack", 32'(bus_b.ack), 32'b0001);
        chk("w1 c4 count", 32'(bus_b.count), 32'd0);
        bus_b.req = 4'b0000;
        tick();
        chk("w1 c5 idle", 32'({bus_b.busy, bus_b.grant}), 32'd0);

        chk("invariants", 32'(inv_bad), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, bits per serial word, legal range 1..31.
REQ-002 The block SHALL have parameter CLKDIV, default 2, serclk half-period in clk cycles, legal range >=1.
REQ-003 The block SHALL have port clk, input, 1, the single system clock, all logic on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port req, input, 4, per-requester transfer request, level, held until ack.
REQ-006 The block SHALL have port data, input, 4*WIDTH, packed words, requester i at bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port grant, output, 4, one-hot owner of the serializer, all-zero when idle.
REQ-008 The block SHALL have port ack, output, 4, one-cycle completion pulse to the granted requester.
REQ-009 The block SHALL have port shld, output, 1, parallel-load strobe to the shift register.
REQ-010 The block SHALL have port serclk, output, 1, serial clock.
REQ-011 The block SHALL have port sdata, output, 1, serial data, MSB first.
REQ-012 The block SHALL have port count, output, 5, bits remaining in the current word.
REQ-013 The block SHALL have port busy, output, 1, high in every non-IDLE state.
REQ-014 The block SHALL have port done, output, 1, one-cycle end-of-word pulse.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, LOAD, SHIFT and DONE.
REQ-016 In IDLE with any req bit set, the block SHALL pick the winner round-robin, register a one-hot grant and go to LOAD next cycle; with req all-zero it SHALL stay in IDLE.
REQ-017 Round-robin SHALL search from (last granted + 1) mod 4 upward; after reset the last granted value SHALL be 3, so req[0] has highest priority.
REQ-018 In LOAD (exactly 1 cycle), the block SHALL hold shld=1, load the shift register from the granted data slice, set count=WIDTH and serclk=0, then go to SHIFT.
REQ-019 In SHIFT, each bit SHALL be CLKDIV cycles with serclk=0 followed by CLKDIV cycles with serclk=1.
REQ-020 sdata SHALL be the shift-register MSB and SHALL be stable throughout each serclk-high phase.
REQ-021 At the end of each serclk-high phase, the block SHALL shift the register left by one, decrement count and drive serclk back to 0.
REQ-022 When count reaches 0, the block SHALL go to DONE.
REQ-023 In DONE (exactly 1 cycle), the block SHALL assert done=1 and ack[granted]=1, record the last-granted pointer, then clear grant and return to IDLE.
REQ-024 Latency: with req sampled in IDLE at cycle 0, LOAD SHALL be at cycle 1, SHIFT SHALL start at cycle 2, and DONE SHALL be at cycle 2+2*CLKDIV*WIDTH.
REQ-025 There SHALL be at least one IDLE cycle between DONE and the next LOAD.
REQ-026 data SHALL be sampled only in LOAD; changes to data during SHIFT SHALL have no effect.
REQ-027 Deassertion of req by the granted requester mid-transfer SHALL be ignored: the word completes and ack still pulses.
REQ-028 req bits from non-granted requesters SHALL be ignored until the next IDLE.
REQ-029 A requester still asserting req in the cycle after its ack SHALL be treated as a new request.
REQ-030 grant SHALL be one-hot or zero at all times.
REQ-031 ack SHALL be a subset of grant.
REQ-032 At most one ack bit SHALL be set per cycle.
REQ-033 In IDLE, serclk and sdata SHALL be 0.

Reset
REQ-034 While reset=1, regardless of clk and mid-transfer, all outputs (grant, ack, shld, serclk, sdata, count, busy, done) SHALL be 0, the state SHALL be IDLE and the last-granted pointer SHALL be 3.
REQ-035 A transfer interrupted by reset SHALL be abandoned and SHALL produce no ack.
REQ-036 After reset deasserts, the first rising clk edge SHALL evaluate IDLE normally.

Verification
REQ-037 Bench SHALL cover: single transfer, WIDTH=16, CLKDIV=2, req=4'b0001, data[15:0]=16'hA5C3 -> shld pulse at cycle 1; sdata sampled on serclk rising = 1010010111000011; done and ack=4'b0001 at cycle 66; count 16->0.
REQ-038 Bench SHALL cover: simultaneous req=4'b1111 held until each ack -> grant sequence 0001, 0010, 0100, 1000; each ack pulses exactly once.
REQ-039 Bench SHALL cover: fairness, req[1] and req[3] held continuously -> grants alternate 0010, 1000, 0010, 1000.
REQ-040 Bench SHALL cover: req[2] dropped at cycle 10 of its transfer -> word completes; ack=4'b0100 at cycle 66.
REQ-041 Bench SHALL cover: reset pulsed mid-SHIFT (count=7) -> all outputs 0 immediately, no ack; a subsequent req=4'b1000 is granted via LOAD one cycle after sampling.
REQ-042 Bench SHALL cover: boundary WIDTH=1, CLKDIV=1 -> serclk 0 then 1 for one cycle each; done at cycle 4.
